cw_bit_reader: RTL

- Parametrised codeword input buffer and variable-length bit reader for the constant-weight decoder family (16-9, 10-38, and later).
- Accepts DEPTH codeword words of CW_W bits through the wr_en/msg_bype write port.
- After start, serves read requests of 1..RD_MAX bits, MSB-first across the concatenated words.
- Tracks remaining bits, full/exhausted state and error flags, so the unranking core only issues rd_req/rd_len.

---
 rtl/cw_bit_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cw_bit_reader.sv
// Codeword input buffer and MSB-first variable-length bit reader for the
// constant-weight decoders: load DEPTH words, then serve 1..RD_MAX bit reads.
module cw_bit_reader #(
    parameter int CW_W   = 16,
    parameter int DEPTH  = 9,
    parameter int RD_MAX = 8,
    parameter int LEN_W  = 4,
    localparam int TOT   = CW_W * DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int BL_W  = $clog2(TOT + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [CW_W-1:0]   msg_bype,
    input  logic              start,
    input  logic              rd_req,
    input  logic [LEN_W-1:0]  rd_len,
    output logic [RD_MAX-1:0] rd_data,
    output logic              rd_vld,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              full,
    output logic [BL_W-1:0]   bits_left,
    output logic              exhausted,
    output logic              ovf_err,
    output logic              udr_err
);

    typedef enum logic [1:0] {LOAD, READ, DONE} state_t;

    state_t            state;
    logic [CW_W-1:0]   slot [DEPTH];
    logic [TOT-1:0]    cw_buf;
    logic [BL_W-1:0]   ptr;

    logic              wr_ok;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BL_W-1:0]   start_bits;
    logic [LEN_W-1:0]  len_c;
    logic [BL_W-1:0]   len_bl;
    logic [BL_W-1:0]   avail;
    logic              short_rd;
    logic [TOT-1:0]    shifted;
    logic [RD_MAX-1:0] win;
    logic [RD_MAX-1:0] keep;
    logic [RD_MAX-1:0] rd_word;

    // Word 0 sits at the top of the flat vector so stream bit k is cw_buf[TOT-1-k].
    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign cw_buf[TOT-1-i*CW_W -: CW_W] = slot[i];
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && !clear && wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_cnt == CNT_W'(i)) slot[i] <= msg_bype;
            end
        end
    end

    always_comb begin
        wr_ok      = wr_en && !full;
        cnt_nxt    = wr_cnt + CNT_W'(wr_ok);
        start_bits = BL_W'(cnt_nxt) * BL_W'(CW_W);
        len_c      = (rd_len > LEN_W'(RD_MAX)) ? LEN_W'(RD_MAX) : rd_len;
        len_bl     = BL_W'(len_c);
        short_rd   = len_bl > bits_left;
        avail      = short_rd ? bits_left : len_bl;
        shifted    = cw_buf << ptr;
        win        = shifted[TOT-1 -: RD_MAX];
        // Bits past the loaded data are stale slots; mask them to zero padding.
        keep       = ~({RD_MAX{1'b1}} >> avail);
        rd_word    = (win & keep) >> (LEN_W'(RD_MAX) - len_c);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= LOAD;
            ptr       <= '0;
            rd_data   <= '0;
            rd_vld    <= 1'b0;
            wr_cnt    <= '0;
            full      <= 1'b0;
            bits_left <= '0;
            exhausted <= 1'b0;
            ovf_err   <= 1'b0;
            udr_err   <= 1'b0;
        end else begin
            rd_vld <= 1'b0;
            if (clear) begin
                state     <= LOAD;
                ptr       <= '0;
                rd_data   <= '0;
                wr_cnt    <= '0;
                full      <= 1'b0;
                bits_left <= '0;
                exhausted <= 1'b0;
                ovf_err   <= 1'b0;
                udr_err   <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (wr_en && full) ovf_err <= 1'b1;
                        wr_cnt <= cnt_nxt;
                        full   <= (cnt_nxt == CNT_W'(DEPTH));
                        if (start && cnt_nxt != '0) begin
                            state     <= READ;
                            bits_left <= start_bits;
                            ptr       <= '0;
                        end
                    end
                    READ: begin
                        if (rd_req && len_c != '0) begin
                            rd_vld  <= 1'b1;
                            rd_data <= rd_word;
                            ptr     <= ptr + len_bl;
                            if (short_rd) begin
                                udr_err   <= 1'b1;
                                bits_left <= '0;
                                exhausted <= 1'b1;
                                state     <= DONE;
                            end else begin
                                bits_left <= bits_left - len_bl;
                                if (len_bl == bits_left) begin
                                    exhausted <= 1'b1;
                                    state     <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        if (rd_req && len_c != '0) begin
                            rd_vld  <= 1'b1;
                            rd_data <= '0;
                            udr_err <= 1'b1;
                        end
                    end
                    default: state <= LOAD;
                endcase
            end
        end
    end

endmodule
